// File: rtl/adat_fogado.sv
// adat_fogado: serial test-data receiver for the QAM datapath.
// Deserialises the bit stream MSB-first into symbols and checks it
// against its own cyclic pattern (self-synchronising, lock + error count).
//
// Optional feature macro: ADAT_FOGADO_PATTERN_CHECK_EN
//   defined     -> pattern checker (history, FILL/HUNT/LOCKED FSM, err_cnt)
//   not defined -> checker removed; locked, bit_err, err_cnt tied to 0
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   synchronous active-low reset
//   adat_be      in   serial data bit
//   data_change  in   bit strobe (one bit per cycle where high)
//   clr_err      in   synchronous clear of err_cnt (wins over an error)
//   symbol       out  last completed symbol, first bit in MSB
//   sym_valid    out  one-cycle pulse when symbol is updated
//   locked       out  checker is in LOCKED
//   bit_err      out  one-cycle pulse on a mismatch while LOCKED
//   err_cnt      out  saturating count of bit_err pulses
module adat_fogado #(
    parameter int SYM_BITS = 4,
    parameter int PAT_LEN  = 28,
    parameter int LOCK_LEN = 28,
    parameter int LOS_LEN  = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                adat_be,
    input  logic                data_change,
    input  logic                clr_err,
    output logic [SYM_BITS-1:0] symbol,
    output logic                sym_valid,
    output logic                locked,
    output logic                bit_err,
    output logic [15:0]         err_cnt
);

    // ---------------- deserialiser ----------------
    localparam int CW = $clog2(SYM_BITS);

    logic [SYM_BITS-2:0] sh;
    logic [CW-1:0]       bcnt;
    logic [SYM_BITS-1:0] word;

    // Word including the bit being sampled this cycle.
    assign word = {sh, adat_be};

    always_ff @(posedge clock) begin
        if (!reset) begin
            sh        <= '0;
            bcnt      <= '0;
            symbol    <= '0;
            sym_valid <= 1'b0;
        end else begin
            sym_valid <= 1'b0;
            if (data_change) begin
                sh <= word[SYM_BITS-2:0];
                if (bcnt == CW'(SYM_BITS - 1)) begin
                    symbol    <= word;
                    sym_valid <= 1'b1;
                    bcnt      <= '0;
                end else begin
                    bcnt <= bcnt + CW'(1);
                end
            end
        end
    end

`ifdef ADAT_FOGADO_PATTERN_CHECK_EN
    // ---------------- pattern checker ----------------
    localparam int FW = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    localparam int MW = $clog2(LOCK_LEN + 1);
    localparam int LW = $clog2(LOS_LEN + 1);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } st_t;

    st_t st, nxt;

    logic [PAT_LEN-1:0] hist;
    logic [FW-1:0]      fill_cnt;
    logic [MW-1:0]      match_cnt;
    logic [LW-1:0]      los_cnt;
    logic               match;
    logic               fill_done;
    logic               hunt_done;
    logic               los_done;

    // The pattern repeats every PAT_LEN bits, so the bit received
    // PAT_LEN strobes ago is the expected value of the current one.
    assign match     = (adat_be == hist[PAT_LEN-1]);
    assign fill_done = (fill_cnt == FW'(PAT_LEN - 1));
    assign hunt_done = match && (match_cnt == MW'(LOCK_LEN - 1));
    assign los_done  = !match && (los_cnt == LW'(LOS_LEN - 1));

    // State register
    always_ff @(posedge clock) begin
        if (!reset) st <= FILL;
        else        st <= nxt;
    end

    // Next-state logic
    always_comb begin
        nxt = st;
        if (data_change) begin
            unique case (st)
                FILL:    if (fill_done) nxt = HUNT;
                HUNT:    if (hunt_done) nxt = LOCKED;
                LOCKED:  if (los_done)  nxt = HUNT;
                default: nxt = FILL;
            endcase
        end
    end

    // Output logic
    always_comb begin
        locked = (st == LOCKED);
    end

    // History, counters and error reporting
    always_ff @(posedge clock) begin
        if (!reset) begin
            hist      <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            los_cnt   <= '0;
            bit_err   <= 1'b0;
        end else begin
            bit_err <= 1'b0;
            if (data_change) begin
                hist <= {hist[PAT_LEN-2:0], adat_be};
                unique case (st)
                    FILL: begin
                        fill_cnt <= fill_done ? '0 : fill_cnt + FW'(1);
                    end
                    HUNT: begin
                        los_cnt <= '0;
                        if (!match || hunt_done) match_cnt <= '0;
                        else match_cnt <= match_cnt + MW'(1);
                    end
                    LOCKED: begin
                        if (match) begin
                            los_cnt <= '0;
                        end else begin
                            bit_err <= 1'b1;
                            if (los_done) begin
                                los_cnt   <= '0;
                                match_cnt <= '0;
                            end else begin
                                los_cnt <= los_cnt + LW'(1);
                            end
                        end
                    end
                    default: fill_cnt <= '0;
                endcase
            end
        end
    end

    // err_cnt moves on the same edge that raises bit_err.
    always_ff @(posedge clock) begin
        if (!reset) begin
            err_cnt <= '0;
        end else if (clr_err) begin
            err_cnt <= '0;
        end else if (data_change && st == LOCKED && !match
                     && err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`else
    logic unused_clr;

    assign locked     = 1'b0;
    assign bit_err    = 1'b0;
    assign err_cnt    = 16'd0;
    assign unused_clr = clr_err;
`endif

endmodule

// File: doc/adat_fogado.md
# adat_fogado

Receive-side counterpart of the serial test-data generator in the QAM datapath. Samples the one-bit serial stream on each bit strobe, deserialises it MSB-first into QAM symbols for the demapper, and checks the stream against its 28-bit cyclic pattern. The checker self-synchronises on the pattern period, reports lock, and counts bit errors. Sits between the channel/bit-recovery stage and the symbol consumer or status registers.

## Interface
Parameters:
- SYM_BITS, 4: bits per symbol, legal 2..8 (4 = 16-QAM).
- PAT_LEN, 28: pattern period in bits, legal 8..64.
- LOCK_LEN, 28: consecutive matches required to declare lock.
- LOS_LEN, 3: consecutive mismatches in LOCKED that drop lock.

Ports:
- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low; 0 on a clock edge clears all state.
- adat_be  in  1  serial data bit.
- data_change  in  1  bit strobe; adat_be is sampled on every edge where this is 1.
- clr_err  in  1  synchronous clear of err_cnt.
- symbol  out  SYM_BITS  last completed symbol, first received bit in MSB.
- sym_valid  out  1  one-cycle pulse: symbol updated.
- locked  out  1  checker in LOCKED state.
- bit_err  out  1  one-cycle pulse: mismatch detected while LOCKED.
- err_cnt  out  16  saturating count of bit_err pulses.

## Operation
- Deserialiser: shift register plus bit counter 0..SYM_BITS-1. Each strobe shifts adat_be in at the LSB. When the counter is SYM_BITS-1, the full word, including the current bit, is loaded into symbol, sym_valid pulses, and the counter wraps to 0. Symbol framing counts from reset only; lock does not realign it.
- Checker history: PAT_LEN-bit shift register of received bits. The expected bit is the bit received PAT_LEN strobes earlier, i.e. the history MSB.
- State machine: FILL, HUNT, LOCKED.
  - FILL: count strobes; after PAT_LEN strobes go to HUNT. No comparisons are made.
  - HUNT: a match increments match_cnt and a mismatch clears it. When the match is the LOCK_LEN-th consecutive one, go to LOCKED and clear match_cnt.
  - LOCKED: a mismatch pulses bit_err, increments err_cnt and increments los_cnt. A match clears los_cnt. When los_cnt reaches LOS_LEN, go to HUNT and clear match_cnt and los_cnt.
- err_cnt saturates at 16'hFFFF. clr_err forces it to 0. If clr_err and an error occur in the same cycle, clear wins and the result is 0.
- Each cycle with data_change=1 is one bit. A strobe held high for N cycles is N bits; this is not edge-detected.
- When reset=0 mid-operation, all registers clear on that edge, state returns to FILL, and any partial symbol is discarded.

## Timing
- Reset values: symbol=0, sym_valid=0, locked=0, bit_err=0, err_cnt=0.
- symbol, sym_valid and bit_err are registered and appear in the cycle after the sampling edge, so latency is 1 clock.
- locked rises or falls in the cycle after the strobe that causes the transition.
- err_cnt shows the new value in the same cycle bit_err is high.
- With no strobe, all state holds and the pulses are 0.
- Strobes may arrive on back-to-back cycles, so full throughput is one bit per clock.

## Configuration
- ADAT_FOGADO_PATTERN_CHECK_EN defined: history register, state machine and error counter are built as above.
- Not defined: the checker is removed. locked, bit_err and err_cnt are tied to 0, clr_err, PAT_LEN, LOCK_LEN and LOS_LEN are ignored, and the deserialiser is unchanged.

## Test plan
- Reset and symbols: reset=0 for 3 cycles, then feed pattern 0110_1100_1100_0001_0101_0101_0101 MSB-first, one strobe every 4 clocks. Required: all outputs 0 during reset; symbols 6,C,C,1,5,5,5 in order, each with one sym_valid pulse 1 clock after the 4th bit.
- Lock: repeat the pattern continuously. Required: locked=0 through strobe 56; locked=1 one cycle after strobe 56; err_cnt stays 0.
- Single error: once locked, invert one bit. Required: one bit_err pulse, err_cnt=1, locked stays 1. Invert 3 consecutive bits: err_cnt=4 and locked=0 after the 3rd.
- Saturation and clear: force 70000 errors, for example with a constant 1 stream after lock plus re-lock cycles, or a preloaded counter in the bench. Required: err_cnt holds 16'hFFFF. Assert clr_err together with an error: err_cnt=0.
- Reset mid-stream: reset=0 after 2 bits of a symbol while locked. Required: locked=0 next cycle, the partial symbol is discarded, and the first post-reset symbol uses the 4 new bits only.
- Back-to-back strobes: data_change held at 1 for 8 clocks carrying 0110_1100. Required: symbols 6 and C on consecutive 4-cycle boundaries.
